mac_62input: RTL and testbench

MAC_62INPUT -- requirements
Module: mac_62input

---
 rtl/mac_62input.sv | 93 +++++++++
 tb/tb_mac_62input.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mac_62input.sv
// mac_62input: 8-lane sign-magnitude multiply-accumulate, two lanes per cycle.
// The externally driven phase index counter_4 picks the lane pair; phase 0
// restarts the accumulator and phase 3 publishes the full dot product.
// Optional feature: define MAC_DONE_EN to add a registered one-cycle 'done'
// pulse that follows every mac_out update.
module mac_62input (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  counter_4,
    input  logic [63:0] weights,
    input  logic [63:0] ins,
    output logic [20:0] mac_out
`ifdef MAC_DONE_EN
    ,
    output logic        done
`endif
);

    // Sign-magnitude product of one lane, widened to the 21-bit result format.
    // A zero magnitude always comes out positive.
    function automatic logic [20:0] lane_product(input logic [7:0] w, input logic [7:0] x);
        logic [13:0] mag;
        logic        sign;
        mag  = {7'b0000000, w[6:0]} * {7'b0000000, x[6:0]};
        sign = (w[7] ^ x[7]) & (mag != 14'd0);
        return {sign, 6'b000000, mag};
    endfunction

    // Sign-magnitude addition; cancellation to zero yields +0.
    function automatic logic [20:0] sm_add(input logic [20:0] a, input logic [20:0] b);
        logic [19:0] mag;
        logic        sign;
        if (a[20] == b[20]) begin
            mag  = a[19:0] + b[19:0];
            sign = a[20];
        end else if (a[19:0] > b[19:0]) begin
            mag  = a[19:0] - b[19:0];
            sign = a[20];
        end else begin
            mag  = b[19:0] - a[19:0];
            sign = b[20];
        end
        if (mag == 20'd0) begin
            sign = 1'b0;
        end
        return {sign, mag};
    endfunction

    logic [20:0] acc;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;
    logic [7:0]  x_lo;
    logic [7:0]  x_hi;
    logic [20:0] pair_sum;
    logic [20:0] acc_base;
    logic [20:0] acc_next;

    // Select the lane pair for this phase and form the running sum.
    always_comb begin
        w_lo     = weights[{counter_4, 4'b0000} +: 8];
        w_hi     = weights[{counter_4, 4'b1000} +: 8];
        x_lo     = ins[{counter_4, 4'b0000} +: 8];
        x_hi     = ins[{counter_4, 4'b1000} +: 8];
        pair_sum = sm_add(lane_product(w_lo, x_lo), lane_product(w_hi, x_hi));
        acc_base = (counter_4 == 2'd0) ? 21'h000000 : acc;
        acc_next = sm_add(acc_base, pair_sum);
    end

    // Accumulate every cycle; publish the total on the phase-3 edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 21'h000000;
            mac_out <= 21'h000000;
        end else begin
            acc <= acc_next;
            if (counter_4 == 2'd3) begin
                mac_out <= acc_next;
            end
        end
    end

`ifdef MAC_DONE_EN
    // One-cycle strobe marking a fresh mac_out value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (counter_4 == 2'd3);
        end
    end
`endif

endmodule

// File: tb/tb_mac_62input.sv
// tb_mac_62input: table-driven check of mac_62input plus hand-written
// sequences for holding, mid-sequence reset and out-of-order phases.
// Checks the optional done pulse when MAC_DONE_EN is defined.
module tb_mac_62input;

    logic        clk;
    logic        rst;
    logic [1:0]  counter_4;
    logic [63:0] weights;
    logic [63:0] ins;
    logic [20:0] mac_out;
`ifdef MAC_DONE_EN
    logic        done;
`endif

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [63:0] w;
        logic [63:0] x;
        logic [20:0] expected;
    } vec_t;

    vec_t vecs[7];

    mac_62input dut (
        .clk       (clk),
        .rst       (rst),
        .counter_4 (counter_4),
        .weights   (weights),
        .ins       (ins),
        .mac_out   (mac_out)
`ifdef MAC_DONE_EN
        ,
        .done      (done)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [20:0] actual, input logic [20:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one phase between edges, clock it, then sample just after the edge.
    task automatic applyStimulus(input logic [1:0] phase, input logic [63:0] w, input logic [63:0] x);
        @(negedge clk);
        counter_4 = phase;
        weights   = w;
        ins       = x;
        @(posedge clk);
        #1;
`ifdef MAC_DONE_EN
        checkOutput("done_pulse", {20'd0, done}, {20'd0, (phase == 2'd3)});
`endif
    endtask

    task automatic runSequence(input logic [63:0] w, input logic [63:0] x);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(p[1:0], w, x);
        end
    endtask

    logic [20:0] held;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        counter_4 = 2'd0;
        weights   = 64'h0;
        ins       = 64'h0;

        vecs[0] = '{"all_max",     64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F, 21'h01F808};
        vecs[1] = '{"neg_lane0",   64'h0000_0000_0000_0083, 64'h0000_0000_0000_0005, 21'h10000F};
        vecs[2] = '{"cancel_zero", 64'h0000_0000_0000_8303, 64'h0000_0000_0000_0505, 21'h000000};
        vecs[3] = '{"mixed_12",    64'h8181_8181_0202_0202, 64'h0101_0101_0202_0202, 21'h00000C};
        vecs[4] = '{"neg_244",     64'hFF00_0000_0000_140A, 64'h0200_0000_0000_0385, 21'h1000F4};
        vecs[5] = '{"cross_zero",  64'h0087_0000_0000_0007, 64'h0001_0000_0000_0001, 21'h000000};
        vecs[6] = '{"ones_8",      64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, 21'h000008};

        #12;
        checkOutput("reset_mac_out", mac_out, 21'h0);
`ifdef MAC_DONE_EN
        checkOutput("reset_done", {20'd0, done}, 21'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            runSequence(vecs[i].w, vecs[i].x);
            checkOutput(vecs[i].name, mac_out, vecs[i].expected);
        end

        // Negative-zero product: -0 * 5 must not yield a negative result.
        runSequence(64'h0000_0000_0000_0080, 64'h0000_0000_0000_0005);
        checkOutput("neg_zero_product", mac_out, 21'h0);

        // mac_out holds through phases 0..2 of the next sequence.
        runSequence(64'h8181_8181_0202_0202, 64'h0101_0101_0202_0202);
        checkOutput("hold_setup", mac_out, 21'h00000C);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(p[1:0], 64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F);
            checkOutput("hold_phase", mac_out, 21'h00000C);
        end
        applyStimulus(2'd3, 64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F);
        checkOutput("hold_release", mac_out, 21'h01F808);

        // Reset asserted after phase 2 clears the output at once.
        held = mac_out;
        for (int p = 0; p < 3; p++) begin
            applyStimulus(p[1:0], 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101);
        end
        checkOutput("pre_reset_hold", mac_out, held);
        rst = 1'b1;
        #1;
        checkOutput("async_reset", mac_out, 21'h0);
        @(negedge clk);
        counter_4 = 2'd3;
        @(posedge clk);
        #1;
        checkOutput("no_update_in_reset", mac_out, 21'h0);
        @(negedge clk);
        rst = 1'b0;
        runSequence(64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101);
        checkOutput("after_reset_ones", mac_out, 21'h000008);

        // Repeated phase keeps accumulating: 2 + 8 + 8 + 2 = 20.
        applyStimulus(2'd0, 64'h0101_0101_0202_0101, 64'h0101_0101_0202_0101);
        applyStimulus(2'd1, 64'h0101_0101_0202_0101, 64'h0101_0101_0202_0101);
        applyStimulus(2'd1, 64'h0101_0101_0202_0101, 64'h0101_0101_0202_0101);
        applyStimulus(2'd3, 64'h0101_0101_0202_0101, 64'h0101_0101_0202_0101);
        checkOutput("repeat_phase", mac_out, 21'h000014);

        // A stray phase before 0 is discarded by the restart: 2 + 8 + 2 + 2 = 14.
        applyStimulus(2'd2, 64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F);
        runSequence(64'h0101_0101_0202_0101, 64'h0101_0101_0202_0101);
        checkOutput("restart_on_zero", mac_out, 21'h00000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
